stable_timer: RTL and testbench

//  Parametrised successor to the free-running stable counter (Scnt). Adds a CSR-programmable

---
 rtl/stable_timer.sv | 121 ++++++++++++
 tb/tb_stable_timer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stable_timer.sv
// stable_timer: free-running stable counter plus a CSR-programmed down-count timer
// with a sticky interrupt flag. Optional tick prescaler: define STABLE_TIMER_PRESCALE_EN.
module stable_timer #(
  parameter int CNT_WIDTH  = 64,
  parameter int TVAL_WIDTH = 32,
  parameter int COUNTER_ID = 0,
  parameter int PRESCALE   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] cnt_value_l,
  output logic [31:0] cnt_value_h,
  output logic [31:0] cnt_id,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  output logic [31:0] tcfg_rdata,
  output logic [31:0] tval_rdata,
  input  logic        ticlr_we,
  input  logic [31:0] ticlr_wdata,
  output logic        timer_int
);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TVAL_WIDTH-1:0] tcfg_q, tcfg_d;
  logic [TVAL_WIDTH-1:0] tval_q, tval_d;
  logic                  ti_q, ti_d;
  logic [TVAL_WIDTH-1:0] init_val, wr_init;
  logic                  en, periodic, tick;
  logic [63:0]           cnt_ext;
  logic                  unused_wdata;

  assign en       = tcfg_q[0];
  assign periodic = tcfg_q[1];
  assign init_val = {tcfg_q[TVAL_WIDTH-1:2], 2'b00};
  assign wr_init  = {tcfg_wdata[TVAL_WIDTH-1:2], 2'b00};

  // Write data bits above the TCFG width and TICLR bits other than bit0 are don't-care.
  assign unused_wdata = ^{tcfg_wdata, ticlr_wdata[31:1]};

`ifdef STABLE_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          presc_hit;

  assign presc_hit = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    if (tcfg_we || !en) begin
      presc_d = '0;
    end else if (presc_hit) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = en & ~tcfg_we & presc_hit;
`else
  assign tick = en & ~tcfg_we;
`endif

  always_comb begin
    cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Clear is applied first so a same-cycle expiry set takes priority.
  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    ti_d   = ti_q;
    if (ticlr_we && ticlr_wdata[0]) begin
      ti_d = 1'b0;
    end
    if (tcfg_we) begin
      tcfg_d = tcfg_wdata[TVAL_WIDTH-1:0];
      tval_d = wr_init;
    end else if (tick) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TVAL_WIDTH'(1);
        if (tval_q == TVAL_WIDTH'(1)) begin
          ti_d = 1'b1;
        end
      end else if (periodic) begin
        tval_d = init_val;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end

  assign cnt_ext     = 64'(cnt_q);
  assign cnt_value_l = cnt_ext[31:0];
  assign cnt_value_h = cnt_ext[63:32];
  assign cnt_id      = 32'(COUNTER_ID);
  assign tcfg_rdata  = 32'(tcfg_q);
  assign tval_rdata  = 32'(tval_q);
  assign timer_int   = ti_q;

endmodule

// File: tb/tb_stable_timer.sv
// Self-checking bench for stable_timer: directed vector table, multi-cycle corner
// sequences and a randomized run against a tick-count reference model.
module tb_stable_timer;

`ifdef STABLE_TIMER_PRESCALE_EN
  localparam int PRESC = 4;
`else
  localparam int PRESC = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  always #5 clk = ~clk;

  logic        tcfg_we, ticlr_we;
  logic [31:0] tcfg_wdata, ticlr_wdata;
  logic [31:0] cnt_l, cnt_h, cnt_id, tcfg_rd, tval_rd;
  logic        tint;

  logic        b_tcfg_we, b_ticlr_we;
  logic [31:0] b_tcfg_wdata, b_ticlr_wdata;
  logic [31:0] b_cnt_l, b_cnt_h, b_cnt_id, b_tcfg_rd, b_tval_rd;
  logic        b_tint;

  stable_timer #(.CNT_WIDTH(64), .TVAL_WIDTH(32), .COUNTER_ID(0), .PRESCALE(PRESC)) dut (
    .clk(clk), .resetn(resetn),
    .cnt_value_l(cnt_l), .cnt_value_h(cnt_h), .cnt_id(cnt_id),
    .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata), .tcfg_rdata(tcfg_rd),
    .tval_rdata(tval_rd), .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata),
    .timer_int(tint)
  );

  stable_timer #(.CNT_WIDTH(33), .TVAL_WIDTH(8), .COUNTER_ID(5), .PRESCALE(PRESC)) dut2 (
    .clk(clk), .resetn(resetn),
    .cnt_value_l(b_cnt_l), .cnt_value_h(b_cnt_h), .cnt_id(b_cnt_id),
    .tcfg_we(b_tcfg_we), .tcfg_wdata(b_tcfg_wdata), .tcfg_rdata(b_tcfg_rd),
    .tval_rdata(b_tval_rd), .ticlr_we(b_ticlr_we), .ticlr_wdata(b_ticlr_wdata),
    .timer_int(b_tint)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic [31:0] wd, input logic cwe, input logic [31:0] cwd);
    tcfg_we     = we;
    tcfg_wdata  = wd;
    ticlr_we    = cwe;
    ticlr_wdata = cwd;
    @(posedge clk);
    #1;
    tcfg_we  = 1'b0;
    ticlr_we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        cwe;
    logic [31:0] cwd;
    logic [31:0] tval;
    logic        ti;
    logic [31:0] tcfg;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] wd, input logic cwe,
                              input logic [31:0] cwd, input logic [31:0] tv, input logic ti,
                              input logic [31:0] cfg);
    vec_t v;
    v.we = we; v.wd = wd; v.cwe = cwe; v.cwd = cwd;
    v.tval = tv; v.ti = ti; v.tcfg = cfg;
    return v;
  endfunction

  // Reference model: timer state is a tick count since the last TCFG write.
  logic [63:0] m_cnt;
  logic [31:0] m_tcfg;
  int          m_k, m_p;
  logic        m_ti;

  function automatic logic [31:0] m_tval();
    longint init;
    init = longint'(m_tcfg & 32'hFFFF_FFFC);
    if (m_tcfg[1]) return 32'(init - (longint'(m_k) % (init + 1)));
    if (longint'(m_k) >= init) return 32'h0;
    return 32'(init - longint'(m_k));
  endfunction

  task automatic m_edge(input logic we, input logic [31:0] wd, input logic cwe, input logic [31:0] cwd);
    longint init;
    logic   set;
    set = 1'b0;
    if (we) begin
      m_tcfg = wd;
      m_k    = 0;
      m_p    = 0;
    end else if (m_tcfg[0]) begin
      m_p++;
      if (m_p == PRESC) begin
        m_p = 0;
        m_k++;
        init = longint'(m_tcfg & 32'hFFFF_FFFC);
        if (init > 0) begin
          if (m_tcfg[1]) set = ((longint'(m_k) % (init + 1)) == init);
          else           set = (longint'(m_k) == init);
        end
      end
    end
    if (cwe && cwd[0]) m_ti = 1'b0;
    if (set) m_ti = 1'b1;
    m_cnt = m_cnt + 64'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[29];
    logic [31:0] wd;
    logic        we, cwe;
    logic [31:0] cwd;

    resetn = 1'b0;
    tcfg_we = 1'b0; tcfg_wdata = '0; ticlr_we = 1'b0; ticlr_wdata = '0;
    b_tcfg_we = 1'b0; b_tcfg_wdata = '0; b_ticlr_we = 1'b0; b_ticlr_wdata = '0;
    #12;
    chk("rst_cnt_l", cnt_l, 0);
    chk("rst_cnt_h", cnt_h, 0);
    chk("rst_tcfg", tcfg_rd, 0);
    chk("rst_tval", tval_rd, 0);
    chk("rst_ti", tint, 0);
    chk("cnt_id", cnt_id, 0);
    chk("cnt_id_b", b_cnt_id, 5);

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("cnt_run%0d", i), cnt_l, i);
      chk($sformatf("cnt_h_run%0d", i), cnt_h, 0);
    end

`ifndef STABLE_TIMER_PRESCALE_EN
    // One-shot InitVal 16: single expiry, then hold at zero.
    step(1'b1, 32'h11, 1'b0, 32'h0);
    chk("os_load_tval", tval_rd, 32'h10);
    chk("os_load_ti", tint, 0);
    for (int j = 1; j <= 16; j++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("os_tval%0d", j), tval_rd, 16 - j);
      chk($sformatf("os_ti%0d", j), tint, (j == 16) ? 1 : 0);
    end
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk("os_hold_tval", tval_rd, 0);
      chk("os_hold_ti", tint, 1);
    end
    step(1'b0, 32'h0, 1'b1, 32'h1);
    chk("os_clr_ti", tint, 0);
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk("os_no_reset_ti", tint, 0);
    end

    vt[0] = mk(1, 32'h0B, 0, 0, 8, 0, 32'h0B);
    for (int i = 1; i <= 8; i++) vt[i] = mk(0, 0, 0, 0, 32'(8 - i), (i == 8), 32'h0B);
    vt[9]  = mk(0, 0, 0, 0, 8, 1, 32'h0B);
    vt[10] = mk(0, 0, 1, 32'h1, 7, 0, 32'h0B);
    for (int i = 11; i <= 16; i++) vt[i] = mk(0, 0, 0, 0, 32'(17 - i), 0, 32'h0B);
    vt[17] = mk(0, 0, 1, 32'h1, 0, 1, 32'h0B);
    vt[18] = mk(0, 0, 0, 0, 8, 1, 32'h0B);
    vt[19] = mk(0, 0, 0, 0, 7, 1, 32'h0B);
    vt[20] = mk(1, 32'h0B, 0, 0, 8, 1, 32'h0B);
    vt[21] = mk(1, 32'h08, 0, 0, 8, 1, 32'h08);
    vt[22] = mk(0, 0, 0, 0, 8, 1, 32'h08);
    vt[23] = mk(0, 0, 1, 32'h2, 8, 1, 32'h08);
    vt[24] = mk(0, 0, 1, 32'h1, 8, 0, 32'h08);
    vt[25] = mk(1, 32'h01, 0, 0, 0, 0, 32'h01);
    vt[26] = mk(0, 0, 0, 0, 0, 0, 32'h01);
    vt[27] = mk(1, 32'h03, 0, 0, 0, 0, 32'h03);
    vt[28] = mk(0, 0, 0, 0, 0, 0, 32'h03);
    for (int i = 0; i < 29; i++) begin
      step(vt[i].we, vt[i].wd, vt[i].cwe, vt[i].cwd);
      chk($sformatf("vec%0d_tval", i), tval_rd, vt[i].tval);
      chk($sformatf("vec%0d_ti", i), tint, vt[i].ti);
      chk($sformatf("vec%0d_tcfg", i), tcfg_rd, vt[i].tcfg);
    end
`else
    // Prescaled one-shot InitVal 8: one decrement every PRESC cycles.
    step(1'b1, 32'h09, 1'b0, 32'h0);
    chk("ps_load_tval", tval_rd, 8);
    for (int c = 1; c <= 32; c++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("ps_tval%0d", c), tval_rd, 32'(8 - c / PRESC));
      chk($sformatf("ps_ti%0d", c), tint, (c == 32) ? 1 : 0);
    end
    step(1'b0, 32'h0, 1'b1, 32'h1);
    chk("ps_clr_ti", tint, 0);
`endif

    // Expire a short one-shot, start another count, then reset asynchronously mid-cycle.
    step(1'b1, 32'h05, 1'b0, 32'h0);
    for (int i = 0; i < 4 * PRESC; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
    chk("pre_rst_ti", tint, 1);
    step(1'b1, 32'h11, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_tval", tval_rd, 0);
    chk("arst_ti", tint, 0);
    chk("arst_tcfg", tcfg_rd, 0);
    chk("arst_cnt_l", cnt_l, 0);
    chk("arst_cnt_h", cnt_h, 0);
    @(posedge clk);
    #1;
    chk("arst_hold_cnt", cnt_l, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 32-bit carry into the high word and full-width wrap.
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    @(posedge clk);
    #1;
    chk("carry_h", cnt_h, 1);
    chk("carry_l", cnt_l, 0);
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    @(posedge clk);
    #1;
    chk("wrap_h", cnt_h, 0);
    chk("wrap_l", cnt_l, 0);

    // Narrow instance: TCFG masked to 8 bits, 33-bit counter zero-extended.
    b_tcfg_we = 1'b1;
    b_tcfg_wdata = 32'hFFFF_FF0B;
    @(posedge clk);
    #1;
    b_tcfg_we = 1'b0;
    chk("n_tcfg", b_tcfg_rd, 32'h0B);
    chk("n_tval", b_tval_rd, 8);
    force dut2.cnt_q = 33'h0_FFFF_FFFF;
    #1;
    release dut2.cnt_q;
    @(posedge clk);
    #1;
    chk("n_carry_h", b_cnt_h, 1);
    chk("n_carry_l", b_cnt_l, 0);
    force dut2.cnt_q = 33'h1_FFFF_FFFF;
    #1;
    release dut2.cnt_q;
    @(posedge clk);
    #1;
    chk("n_wrap_h", b_cnt_h, 0);
    chk("n_wrap_l", b_cnt_l, 0);

    // Randomized run from a fresh reset against the reference model.
    #2;
    resetn = 1'b0;
    #1;
    m_cnt = 64'd0; m_tcfg = 32'd0; m_k = 0; m_p = 0; m_ti = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      we  = ($urandom_range(0, 19) == 0);
      wd  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3) != 0)
            | (32'($urandom_range(0, 1)) << 1);
      cwe = ($urandom_range(0, 7) == 0);
      cwd = $urandom;
      step(we, wd, cwe, cwd);
      m_edge(we, wd, cwe, cwd);
      chk("rnd_tval", tval_rd, m_tval());
      chk("rnd_ti", tint, m_ti);
      chk("rnd_tcfg", tcfg_rd, m_tcfg);
      chk("rnd_cnt_l", cnt_l, m_cnt[31:0]);
      chk("rnd_cnt_h", cnt_h, m_cnt[63:32]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
